// File: rtl/mbist_ctrl.sv
// March C- MBIST sequencer for a single-port synchronous SRAM, controlled through a JTAG command/status DR.
// Optional build macro MBIST_STOP_ON_FAIL_EN: end the run at the first detected mismatch.
module mbist_ctrl #(
    parameter  int ADDR_W = 6,
    parameter  int DATA_W = 8,
    localparam int DR_W   = ADDR_W + 4
) (
    input  logic              tck_i,
    input  logic              test_logic_reset_i,
    input  logic              mbist_select_i,
    input  logic              capture_dr_i,
    input  logic              shift_dr_i,
    input  logic              update_dr_i,
    input  logic              tdi_i,
    output logic              tdo_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]        ELEM_LAST = 3'd5;

    // Elements M3 and M4 walk the array downwards.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic elem_two(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic op_write(input logic [2:0] e, input logic ph);
        return (e == 3'd0) || ph;
    endfunction

    // Data polarity relative to the background: 1 selects ~B.
    function automatic logic op_inv(input logic [2:0] e, input logic ph);
        logic inv;
        case (e)
            3'd1, 3'd3: inv = ph;
            3'd2, 3'd4: inv = ~ph;
            default:    inv = 1'b0;
        endcase
        return inv;
    endfunction

    function automatic logic [ADDR_W-1:0] first_addr(input logic [2:0] e);
        return elem_down(e) ? ADDR_MAX : ADDR_ZERO;
    endfunction

    function automatic logic [ADDR_W-1:0] last_addr(input logic [2:0] e);
        return elem_down(e) ? ADDR_ZERO : ADDR_MAX;
    endfunction

    state_t              state_r, state_nx_s;
    logic [2:0]          elem_r, elem_nx_s;
    logic                phase_r, phase_nx_s;
    logic [ADDR_W-1:0]   addr_r, addr_nx_s;
    logic                bg_r, bg_nx_s;
    logic [DR_W-1:0]     sr_r;
    logic                busy_r, done_r, fail_r;
    logic [ADDR_W-1:0]   fail_addr_r;
    logic                mem_en_r, mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                cmp_pend_r;
    logic [DATA_W-1:0]   cmp_exp_r;
    logic [ADDR_W-1:0]   cmp_addr_r;
    logic                dr_cap_s, dr_shift_s, dr_upd_s;
    logic                start_s, abort_s, mismatch_s, first_fail_s, stop_s;
    logic                run_nx_s;

    assign dr_cap_s     = mbist_select_i & capture_dr_i;
    assign dr_shift_s   = mbist_select_i & shift_dr_i & ~capture_dr_i;
    assign dr_upd_s     = mbist_select_i & update_dr_i & ~capture_dr_i & ~shift_dr_i;
    assign abort_s      = dr_upd_s & sr_r[1];
    assign start_s      = dr_upd_s & sr_r[0] & ~sr_r[1] & ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign mismatch_s   = cmp_pend_r & (mem_rdata_i != cmp_exp_r);
    assign first_fail_s = mismatch_s & ~fail_r;
`ifdef MBIST_STOP_ON_FAIL_EN
    assign stop_s       = first_fail_s;
`else
    assign stop_s       = 1'b0;
`endif
    assign run_nx_s     = (state_nx_s == ST_RUN);

    // Next-state sequencing through elements, phases and addresses.
    always_comb begin
        state_nx_s = state_r;
        elem_nx_s  = elem_r;
        phase_nx_s = phase_r;
        addr_nx_s  = addr_r;
        bg_nx_s    = bg_r;
        if (abort_s) begin
            state_nx_s = ST_IDLE;
        end else if (start_s) begin
            state_nx_s = ST_RUN;
            elem_nx_s  = 3'd0;
            phase_nx_s = 1'b0;
            addr_nx_s  = ADDR_ZERO;
            bg_nx_s    = sr_r[2];
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (stop_s) begin
                        state_nx_s = ST_DONE;
                    end else if (elem_two(elem_r) && !phase_r) begin
                        phase_nx_s = 1'b1;
                    end else begin
                        phase_nx_s = 1'b0;
                        if (addr_r != last_addr(elem_r)) begin
                            addr_nx_s = elem_down(elem_r) ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
                        end else if (elem_r == ELEM_LAST) begin
                            state_nx_s = ST_DRAIN;
                        end else begin
                            elem_nx_s = elem_r + 3'd1;
                            addr_nx_s = first_addr(elem_r + 3'd1);
                        end
                    end
                end
                ST_DRAIN: state_nx_s = ST_DONE;
                ST_IDLE:  state_nx_s = ST_IDLE;
                ST_DONE:  state_nx_s = ST_DONE;
                default:  state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FSM, status and registered SRAM port.
    always_ff @(posedge tck_i) begin
        if (test_logic_reset_i) begin
            state_r     <= ST_IDLE;
            elem_r      <= 3'd0;
            phase_r     <= 1'b0;
            addr_r      <= ADDR_ZERO;
            bg_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= ADDR_ZERO;
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            elem_r      <= elem_nx_s;
            phase_r     <= phase_nx_s;
            addr_r      <= addr_nx_s;
            bg_r        <= bg_nx_s;
            busy_r      <= run_nx_s || (state_nx_s == ST_DRAIN);
            done_r      <= (state_nx_s == ST_DONE);
            mem_en_r    <= run_nx_s;
            mem_we_r    <= run_nx_s & op_write(elem_nx_s, phase_nx_s);
            mem_addr_r  <= run_nx_s ? addr_nx_s : ADDR_ZERO;
            mem_wdata_r <= run_nx_s ? {DATA_W{bg_nx_s ^ op_inv(elem_nx_s, phase_nx_s)}} : {DATA_W{1'b0}};
        end
    end

    // Read compare, one cycle behind the SRAM read data; the first failure is sticky.
    always_ff @(posedge tck_i) begin
        if (test_logic_reset_i) begin
            cmp_pend_r  <= 1'b0;
            cmp_exp_r   <= {DATA_W{1'b0}};
            cmp_addr_r  <= ADDR_ZERO;
            fail_r      <= 1'b0;
            fail_addr_r <= ADDR_ZERO;
        end else begin
            cmp_pend_r <= mem_en_r & ~mem_we_r & ~abort_s & ~stop_s;
            cmp_exp_r  <= mem_wdata_r;
            cmp_addr_r <= mem_addr_r;
            if (start_s) begin
                fail_r      <= 1'b0;
                fail_addr_r <= ADDR_ZERO;
            end else if (first_fail_s) begin
                fail_r      <= 1'b1;
                fail_addr_r <= cmp_addr_r;
            end else begin
                fail_r      <= fail_r;
                fail_addr_r <= fail_addr_r;
            end
        end
    end

    // Command/status shift register.
    always_ff @(posedge tck_i) begin
        if (test_logic_reset_i) begin
            sr_r <= {DR_W{1'b0}};
        end else if (dr_cap_s) begin
            sr_r <= {fail_addr_r, 1'b0, fail_r, done_r, busy_r};
        end else if (dr_shift_s) begin
            sr_r <= {tdi_i, sr_r[DR_W-1:1]};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign tdo_o       = sr_r[0];
    assign mem_en_o    = mem_en_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign fail_o      = fail_r;

endmodule

// File: tb/tb_mbist_ctrl.sv
// Self-checking bench for mbist_ctrl (ADDR_W=2) against a March C- operation-list reference model.
module tb_mbist_ctrl;

    localparam int AW      = 2;
    localparam int DW      = 8;
    localparam int DRW     = AW + 4;
    localparam int NW      = 1 << AW;
    localparam int NOPS    = 10 * NW;
    localparam int RUN_LEN = NOPS + 1;
`ifdef MBIST_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic          tck = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0, cap = 1'b0, shf = 1'b0, upd = 1'b0, tdi = 1'b0;
    logic          tdo, mem_en, mem_we, busy, done, fail;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    bit fault_en  = 1'b0;
    int fault_addr = 0;
    int fault_bit  = 0;
    bit fault_val  = 1'b0;

    typedef struct {
        bit            we;
        int            addr;
        logic [DW-1:0] d;
    } op_t;
    op_t exp_q[$];

    mbist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .tck_i(tck), .test_logic_reset_i(rst), .mbist_select_i(sel),
        .capture_dr_i(cap), .shift_dr_i(shf), .update_dr_i(upd), .tdi_i(tdi), .tdo_o(tdo),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .done_o(done), .fail_o(fail)
    );

    always #5 tck = ~tck;

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
        logic [DW-1:0] r;
        r = v;
        if (fault_en && a == fault_addr) r[fault_bit] = fault_val;
        return r;
    endfunction

    // Behavioural SRAM with one-cycle read latency and an optional stuck-at bit.
    logic [DW-1:0] sram [NW];
    always @(posedge tck) begin
        if (mem_en && !mem_we) mem_rdata <= faulty(sram[mem_addr], int'(mem_addr));
        if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Expand March C- into its operation list and find the first failing read.
    task automatic build_ref(input bit bg, output int fidx, output int fa);
        int            nops[6] = '{1, 2, 2, 2, 2, 1};
        bit            down[6] = '{0, 0, 0, 1, 1, 0};
        bit            we0[6]  = '{1, 0, 0, 0, 0, 0};
        bit            pol0[6] = '{0, 0, 1, 0, 1, 0};
        bit            pol1[6] = '{0, 1, 0, 1, 0, 0};
        logic [DW-1:0] mm[NW];
        logic [DW-1:0] rd;
        int            a;
        bit            pol, we;
        exp_q.delete();
        for (int m = 0; m < 6; m++) begin
            for (int s = 0; s < NW; s++) begin
                a = down[m] ? (NW - 1 - s) : s;
                for (int o = 0; o < nops[m]; o++) begin
                    we  = (o == 0) ? we0[m] : 1'b1;
                    pol = (o == 0) ? pol0[m] : pol1[m];
                    exp_q.push_back('{we, a, {DW{bg ^ pol}}});
                end
            end
        end
        fidx = -1;
        fa   = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].we) begin
                mm[exp_q[i].addr] = exp_q[i].d;
            end else begin
                rd = faulty(mm[exp_q[i].addr], exp_q[i].addr);
                if (rd !== exp_q[i].d && fidx < 0) begin
                    fidx = i;
                    fa   = exp_q[i].addr;
                end
            end
        end
    endtask

    task automatic dr_update(input logic [DRW-1:0] dr);
        sel = 1'b1;
        for (int i = 0; i < DRW; i++) begin
            shf = 1'b1;
            tdi = dr[i];
            @(negedge tck);
        end
        shf = 1'b0;
        tdi = 1'b0;
        upd = 1'b1;
        @(negedge tck);
        upd = 1'b0;
    endtask

    task automatic dr_capture(output logic [DRW-1:0] v);
        sel = 1'b1;
        cap = 1'b1;
        @(negedge tck);
        cap = 1'b0;
        shf = 1'b1;
        tdi = 1'b0;
        for (int i = 0; i < DRW; i++) begin
            v[i] = tdo;
            @(negedge tck);
        end
        shf = 1'b0;
    endtask

    // kind: 0 plain run, 1 re-issue update at inj_cyc, 2 shift inj_dr then update, 3 reset pulse.
    task automatic run_check(input string name, input logic [DRW-1:0] dr, input int kind,
                             input int inj_cyc, input logic [DRW-1:0] inj_dr);
        int             fidx, fa, run_len, last_op, lim, b;
        bit             exp_fail, en_seen;
        logic [31:0]    ob, ex;
        logic [DRW-1:0] st;
        op_t            op;
        build_ref(dr[2], fidx, fa);
        exp_fail = (fidx >= 0);
        run_len  = (STOP_EN && exp_fail) ? fidx + 2 : RUN_LEN;
        last_op  = (run_len < NOPS) ? run_len : NOPS;
        lim      = (kind >= 2) ? inj_cyc : run_len;
        dr_update(dr);
        for (int k = 1; k <= lim; k++) begin
            if (k <= last_op) begin
                op = exp_q[k-1];
                ex = {19'd0, 1'b1, 1'b1, op.we, 2'(op.addr), op.we ? op.d : 8'h00};
            end else begin
                ex = {19'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00};
            end
            ob = {19'd0, busy, mem_en, mem_we, mem_en ? mem_addr : 2'b00, mem_we ? mem_wdata : 8'h00};
            check($sformatf("%s cyc%0d busy/op", name, k), ob, ex);
            b   = k - (inj_cyc - DRW);
            shf = (kind == 2) && (b >= 0) && (b < DRW);
            tdi = shf ? inj_dr[b] : 1'b0;
            upd = (kind == 1 || kind == 2) && (k == inj_cyc);
            rst = (kind == 3) && (k == inj_cyc);
            @(negedge tck);
            shf = 1'b0;
            tdi = 1'b0;
            upd = 1'b0;
            rst = 1'b0;
        end
        if (kind <= 1) begin
            check({name, " end status"}, {28'd0, busy, done, fail, mem_en}, {28'd0, 1'b0, 1'b1, exp_fail, 1'b0});
            dr_capture(st);
            check({name, " captured"}, 32'(st), 32'({exp_fail ? 2'(fa) : 2'b00, 1'b0, exp_fail, 1'b1, 1'b0}));
        end else if (kind == 2) begin
            check({name, " after abort"}, {29'd0, busy, done, mem_en}, 32'd0);
        end else begin
            check({name, " after reset"},
                  {17'd0, busy, done, fail, mem_en, mem_we, mem_addr, mem_wdata, tdo}, 32'd0);
            en_seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                en_seen |= mem_en;
                @(negedge tck);
            end
            check({name, " no access"}, 32'(en_seen), 32'd0);
        end
    endtask

    initial begin
        logic [DRW-1:0] st;
        logic [DRW-1:0] rdr;
        bit             seen;
        repeat (2) @(negedge tck);
        check("reset outputs", {17'd0, busy, done, fail, mem_en, mem_we, mem_addr, mem_wdata, tdo}, 32'd0);
        rst = 1'b0;
        @(negedge tck);

        run_check("clean", 6'h01, 0, 0, 6'h00);
        run_check("bginv", 6'h05, 0, 0, 6'h00);

        fault_en = 1'b1; fault_addr = 2; fault_bit = 0; fault_val = 1'b1;
        run_check("stuck", 6'h01, 0, 0, 6'h00);
        dr_capture(st);
        check("stuck status", 32'(st), 32'h26);
        fault_en = 1'b0;

        run_check("abort", 6'h01, 2, 10, 6'h02);
        run_check("post-abort", 6'h01, 0, 0, 6'h00);
        run_check("start-busy", 6'h01, 1, 5, 6'h00);

        dr_update(6'h03);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen |= busy | done | mem_en;
            @(negedge tck);
        end
        check("start+abort idle", 32'(seen), 32'd0);

        run_check("midreset", 6'h01, 3, 20, 6'h00);

        for (int r = 0; r < 6; r++) begin
            fault_en   = 1'($urandom_range(0, 1));
            fault_addr = $urandom_range(0, NW - 1);
            fault_bit  = $urandom_range(0, DW - 1);
            fault_val  = 1'($urandom_range(0, 1));
            rdr = {3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 1'b1};
            run_check($sformatf("rand%0d", r), rdr, 0, 0, 6'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
